vram_fill_arbiter: RTL and testbench

VRAM_FILL_ARBITER -- requirements
Module: vram_fill_arbiter

---
 rtl/vram_fill_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vram_fill_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fill_arbiter.sv
// Rectangle fill engine sharing one VRAM write port with the CPU.
// CPU writes always win; the fill stalls for that cycle.
module vram_fill_arbiter #(
  parameter int VGA_WIDTH  = 320,
  parameter int VGA_HEIGHT = 200
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cmd_start,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [7:0]  cmd_color,
  output logic        vram_wr,
  output logic [15:0] vram_addr,
  output logic [7:0]  vram_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    FILL,
    DONE
  } state_e;

  localparam logic [9:0] W10 = 10'(VGA_WIDTH);
  localparam logic [8:0] H9  = 9'(VGA_HEIGHT);

  state_e      state_q, state_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [8:0]  w_q, w_d;
  logic [7:0]  h_q, h_d;
  logic [7:0]  color_q, color_d;
  logic [8:0]  ew_q, ew_d;
  logic [7:0]  eh_q, eh_d;
  logic [8:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [15:0] base_q, base_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic [9:0]  rem_w;
  logic [8:0]  rem_h;
  logic        x_oob;
  logic        y_oob;
  logic [8:0]  clip_w;
  logic [7:0]  clip_h;
  logic        empty;

  always_comb begin
    rem_w  = W10 - {1'b0, x_q};
    rem_h  = H9 - {1'b0, y_q};
    x_oob  = ({1'b0, x_q} >= W10);
    y_oob  = ({1'b0, y_q} >= H9);
    clip_w = (rem_w > {1'b0, w_q}) ? w_q : rem_w[8:0];
    clip_h = (rem_h > {1'b0, h_q}) ? h_q : rem_h[7:0];
    empty  = x_oob || y_oob || (clip_w == 9'd0) || (clip_h == 8'd0);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    color_d = color_q;
    ew_d    = ew_q;
    eh_d    = eh_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (cpu_wr) begin
      wr_d   = 1'b1;
      addr_d = cpu_addr;
      data_d = cpu_data;
    end

    unique case (state_q)
      IDLE: begin
        if (cmd_start) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = SETUP;
        end
      end
      SETUP: begin
        col_d  = 9'd0;
        row_d  = 8'd0;
        ew_d   = clip_w;
        eh_d   = clip_h;
        // constant multiply reduces to shift-adds
        base_d = 16'(32'(y_q) * 32'(VGA_WIDTH)) + 16'(x_q);
        state_d = empty ? DONE : FILL;
      end
      FILL: begin
        if (!cpu_wr) begin
          wr_d   = 1'b1;
          addr_d = base_q + 16'(col_q);
          data_d = color_q;
          if (col_q == ew_q - 9'd1) begin
            col_d  = 9'd0;
            row_d  = row_q + 8'd1;
            base_d = base_q + 16'(VGA_WIDTH);
            if (row_q == eh_q - 8'd1) begin
              state_d = DONE;
            end
          end else begin
            col_d = col_q + 9'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      ew_q    <= '0;
      eh_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      color_q <= color_d;
      ew_q    <= ew_d;
      eh_q    <= eh_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign vram_wr   = wr_q;
  assign vram_addr = addr_q;
  assign vram_data = data_q;
  assign busy      = (state_q == SETUP) || (state_q == FILL);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_vram_fill_arbiter.sv
// Scoreboard bench for vram_fill_arbiter: expected writes queued
// at stimulus time, popped as VRAM writes appear.
module tb_vram_fill_arbiter;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cmd_start;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [7:0]  cmd_color;
  logic        vram_wr;
  logic [15:0] vram_addr;
  logic [7:0]  vram_data;
  logic        busy;
  logic        done;

  always #5 cpu_clk = ~cpu_clk;

  vram_fill_arbiter dut (
    .cpu_clk   (cpu_clk),
    .reset     (reset),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cmd_start (cmd_start),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .vram_wr   (vram_wr),
    .vram_addr (vram_addr),
    .vram_data (vram_data),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  int  vectors  = 0;
  int  errors   = 0;
  int  busy_cnt = 0;
  int  done_cnt = 0;

  always @(negedge cpu_clk) begin
    wr_t e;
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (vram_wr === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got %h/%h required none",
                 vram_addr, vram_data);
      end else begin
        e = exp_q.pop_front();
        if ({vram_addr, vram_data} !== e) begin
          errors++;
          $display("FAIL write got %h/%h required %h/%h",
                   vram_addr, vram_data, e.a, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic push_rect(input int x, input int y, input int w,
                           input int h, input logic [7:0] c);
    int ew, eh;
    wr_t e;
    if (x >= 320 || y >= 200) return;
    ew = (w < 320 - x) ? w : 320 - x;
    eh = (h < 200 - y) ? h : 200 - y;
    for (int r = 0; r < eh; r++) begin
      for (int k = 0; k < ew; k++) begin
        e.a = 16'((y + r) * 320 + x + k);
        e.d = c;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic start_cmd(input int x, input int y, input int w,
                           input int h, input logic [7:0] c);
    cmd_x     = 9'(x);
    cmd_y     = 8'(y);
    cmd_w     = 9'(w);
    cmd_h     = 8'(h);
    cmd_color = c;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge cpu_clk);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
    end
    vectors++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout got no done required done", name);
    end
    tick();
  endtask

  task automatic check_end(input string name, input int b0, input int d0,
                           input int exp_busy);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing got %0d pending required 0",
               name, exp_q.size());
      exp_q.delete();
    end
    vectors++;
    if (busy_cnt - b0 != exp_busy) begin
      errors++;
      $display("FAIL %s_busy got %0d cycles required %0d",
               name, busy_cnt - b0, exp_busy);
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL %s_done got %0d pulses required 1",
               name, done_cnt - d0);
    end
  endtask

  task automatic run_fill(input string name, input int x, input int y,
                          input int w, input int h, input logic [7:0] c,
                          input int exp_busy);
    int b0, d0;
    b0 = busy_cnt;
    d0 = done_cnt;
    push_rect(x, y, w, h, c);
    start_cmd(x, y, w, h, c);
    wait_done(name);
    check_end(name, b0, d0, exp_busy);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cmd_start = 1'b1;
    cpu_wr    = 1'b1;
    cpu_addr  = 16'hABCD;
    cpu_data  = 8'h77;
    cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd4; cmd_h = 8'd4;
    cmd_color = 8'hFF;
    tick();
    tick();
    vectors++;
    if ({vram_wr, vram_addr, vram_data, busy, done} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got wr=%b a=%h d=%h b=%b dn=%b required 0",
               vram_wr, vram_addr, vram_data, busy, done);
    end
    cmd_start = 1'b0;
    cpu_wr    = 1'b0;
    reset     = 1'b0;
    tick();
    vectors++;
    if ({vram_wr, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release got wr=%b busy=%b required 0/0",
               vram_wr, busy);
    end
  endtask

  task automatic test_cpu_pass();
    wr_t e;
    e.a = 16'hBEEF;
    e.d = 8'h5A;
    exp_q.push_back(e);
    cpu_wr   = 1'b1;
    cpu_addr = 16'hBEEF;
    cpu_data = 8'h5A;
    tick();
    cpu_wr   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
    tick();
    vectors++;
    if ({vram_wr, vram_addr, vram_data} !== {1'b0, 16'hBEEF, 8'h5A}) begin
      errors++;
      $display("FAIL cpu_hold got wr=%b %h/%h required 0 beef/5a",
               vram_wr, vram_addr, vram_data);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL cpu_pass got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_cpu_priority();
    int  b0, d0;
    wr_t e;
    b0 = busy_cnt;
    d0 = done_cnt;
    e.d = 8'h3C;
    e.a = 16'd0;    exp_q.push_back(e);
    e.a = 16'h1234; e.d = 8'h55; exp_q.push_back(e);
    e.d = 8'h3C;
    e.a = 16'd1;    exp_q.push_back(e);
    e.a = 16'd2;    exp_q.push_back(e);
    e.a = 16'd3;    exp_q.push_back(e);
    start_cmd(0, 0, 4, 1, 8'h3C);
    tick();
    tick();
    cpu_wr   = 1'b1;
    cpu_addr = 16'h1234;
    cpu_data = 8'h55;
    tick();
    cpu_wr   = 1'b0;
    wait_done("cpu_prio");
    check_end("cpu_prio", b0, d0, 6);
  endtask

  task automatic test_restart_ignored();
    int b0, d0;
    b0 = busy_cnt;
    d0 = done_cnt;
    push_rect(5, 5, 4, 3, 8'h92);
    start_cmd(5, 5, 4, 3, 8'h92);
    tick();
    tick();
    tick();
    cmd_x = 9'd100; cmd_y = 8'd100; cmd_w = 9'd2; cmd_h = 8'd2;
    cmd_color = 8'h11;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wait_done("restart");
    check_end("restart", b0, d0, 13);
    tick();
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_idle got busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_midfill();
    int  d0;
    wr_t e;
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      e.a = 16'(i);
      e.d = 8'hC3;
      exp_q.push_back(e);
    end
    start_cmd(0, 0, 320, 200, 8'hC3);
    tick();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    vectors++;
    if ({vram_wr, busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort_out got wr=%b busy=%b required 0/0",
               vram_wr, busy);
    end
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if (done_cnt != d0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_state got done=%0d pending=%0d required 0/0",
               done_cnt - d0, exp_q.size());
      exp_q.delete();
    end
    run_fill("after_abort", 1, 1, 2, 2, 8'h07, 5);
  endtask

  initial begin
    reset     = 1'b1;
    cpu_wr    = 1'b0;
    cpu_addr  = '0;
    cpu_data  = '0;
    cmd_start = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

    test_reset();
    test_cpu_pass();
    run_fill("basic", 10, 2, 3, 2, 8'hE0, 7);
    run_fill("clip", 318, 199, 5, 4, 8'h1F, 3);
    run_fill("single", 319, 0, 1, 1, 8'h42, 2);
    test_cpu_priority();
    run_fill("empty_w", 20, 20, 0, 5, 8'hAA, 1);
    run_fill("empty_x", 320, 10, 4, 4, 8'hAA, 1);
    run_fill("empty_y", 10, 200, 4, 4, 8'hAA, 1);
    test_restart_ignored();
    test_reset_midfill();
    run_fill("full", 0, 0, 320, 200, 8'h1C, 64001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
